fetch_ctrl: RTL and testbench

//  Instruction-fetch controller. Sequences the PC that addresses the asynchronous

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // Encoding of addi x0,x0,0; shown on the head outputs out of reset.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // Instruction fetch targets must be word aligned.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer built as a shift register so that the head entry is
// always slot 0, a plain flop, and the head outputs are registered.
module fetch_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned W          = 64,
  parameter logic [W-1:0] RESET_HEAD = '0,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  q     [DEPTH];
  logic [W-1:0]  q_d   [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] wr_cnt;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && !flush && (!full || pop_ok);

  assign head  = q[0];
  assign count = cnt_q;

  // Next slot contents: shift down on pop, then write behind the last live entry.
  always_comb begin
    q_d    = q;
    wr_cnt = cnt_q - CW'(pop_ok);
    if (pop_ok) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        q_d[i] = q[i + 1];
      end
    end
    if (push_ok) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CW'(i) == wr_cnt) begin
          q_d[i] = din;
        end
      end
    end
  end

  // Occupancy: flush drops everything, including a same-cycle push.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q[i] <= (i == 0) ? RESET_HEAD : '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q[i] <= q_d[i];
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences the PC into an asynchronous ROM and
// queues {pc, instr} pairs toward decode, with redirect/flush, halt and a
// sticky fault on misaligned redirect targets.
module fetch_ctrl #(
  parameter int unsigned    ADDR_W     = 8,
  parameter int unsigned    XLEN       = 32,
  parameter int unsigned    FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              halt_req,
  input  logic              redirect_vld,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic              fault,
  output logic [1:0]        state
);

  import cpu_pkg::*;

  localparam int unsigned    EW         = 2 * XLEN;
  localparam int unsigned    CW         = $clog2(FIFO_DEPTH + 1);
  // Head shows pc=0 / NOP until the first real entry arrives.
  localparam logic [EW-1:0]  RESET_HEAD = {{XLEN{1'b0}}, XLEN'(NOP_INSTR)};

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            fault_q;
  logic            fault_d;

  logic            push;
  logic            pop;
  logic            flush;
  logic            can_push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;

  // ROM is word addressed; PC bits above the ROM range simply alias.
  assign rom_addr  = pc_q[ADDR_W+1:2];

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_head[EW-1:XLEN];
  assign out_instr = fifo_head[XLEN-1:0];
  assign fault     = fault_q;
  assign state     = state_q;

  assign pop       = out_valid && out_ready;
  // A slot is available if the buffer is not full or the head drains this cycle.
  assign can_push  = (fifo_count != CW'(FIFO_DEPTH)) || pop;

  // Next state, next PC and buffer control; priority redirect > halt > enable.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;

    case (state_q)
      IDLE, RUN, HALT: begin
        if (redirect_vld) begin
          flush = 1'b1;
          if (is_word_aligned(redirect_pc[1:0])) begin
            state_d = RUN;
            pc_d    = redirect_pc;
          end else begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end else if (halt_req) begin
          state_d = HALT;
        end else begin
          case (state_q)
            IDLE: begin
              if (enable) begin
                state_d = RUN;
              end
            end
            RUN: begin
              if (!enable) begin
                state_d = IDLE;
              end else if (can_push) begin
                push = 1'b1;
                pc_d = pc_q + XLEN'(4);
              end
            end
            default: begin
              // HALT waits for an aligned redirect; enable has no effect.
            end
          endcase
        end
      end
      default: begin
        // FAULT is terminal until reset.
      end
    endcase
  end

  // FSM, PC and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .W          (EW),
    .RESET_HEAD (RESET_HEAD)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({pc_q, rom_data}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Full is implied by the count compare above; kept on the buffer interface.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with a small behavioural ROM.
module tb_fetch_ctrl;

  import cpu_pkg::*;

  localparam logic [31:0] I0 = 32'h00200093;
  localparam logic [31:0] I1 = 32'h00300113;
  localparam logic [31:0] I2 = 32'h002081b3;
  localparam logic [31:0] I3 = 32'h00400213;
  localparam logic [31:0] I4 = 32'h003202b3;
  localparam logic [31:0] NP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [1:0]  state;

  logic [31:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  fetch_ctrl #(
    .ADDR_W     (8),
    .XLEN       (32),
    .FIFO_DEPTH (2),
    .RESET_PC   (32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .halt_req     (halt_req),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .fault        (fault),
    .state        (state)
  );

  typedef struct {
    logic         rs;
    logic         en;
    logic         hr;
    logic         rv;
    logic [31:0]  rpc;
    logic         rdy;
    logic         ev;
    logic [31:0]  epc;
    logic [31:0]  ein;
    fetch_state_t est;
    logic         ef;
    logic [7:0]   erom;
  } vec_t;

  vec_t vt[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic rs, input logic en, input logic hr,
                              input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                              input fetch_state_t est, input logic ef, input logic [7:0] erom);
    vec_t v;
    v.rs = rs; v.en = en; v.hr = hr; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ein = ein; v.est = est; v.ef = ef; v.erom = erom;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_pc"},    out_pc,         32'h0);
    check({tag, " out_instr"}, out_instr,      NP);
    check({tag, " state"},     32'(state),     32'(IDLE));
    check({tag, " fault"},     32'(fault),     32'd0);
    check({tag, " rom_addr"},  32'(rom_addr),  32'd0);
  endtask

  task automatic do_reset(input string tag);
    enable       = 1'b0;
    halt_req     = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    out_ready    = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = NP;
    rom[0] = I0; rom[1] = I1; rom[2] = I2; rom[3] = I3; rom[4] = I4;

    // Streaming after enable: first valid two cycles later, one instr per cycle.
    vt.push_back(mk(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,   32'h0, RUN,   0, 8'd0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h0,   I0,    RUN,   0, 8'd1));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h4,   I1,    RUN,   0, 8'd2));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h8,   I2,    RUN,   0, 8'd3));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'hC,   I3,    RUN,   0, 8'd4));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h10,  I4,    RUN,   0, 8'd5));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h14,  NP,    RUN,   0, 8'd6));
    // Back-pressure: two entries buffered, pc parks at 8, then ordered drain.
    vt.push_back(mk(1, 1, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0, RUN,   0, 8'd0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'h0,   I0,    RUN,   0, 8'd1));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'h0,   I0,    RUN,   0, 8'd2));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'h0,   I0,    RUN,   0, 8'd2));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'h0,   I0,    RUN,   0, 8'd2));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'h0,   I0,    RUN,   0, 8'd2));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h4,   I1,    RUN,   0, 8'd3));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h8,   I2,    RUN,   0, 8'd4));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'hC,   I3,    RUN,   0, 8'd5));
    // Redirect to 0xC while head pc=4 is being popped.
    vt.push_back(mk(1, 1, 0, 0, 32'h0,   1, 0, 32'h0,   32'h0, RUN,   0, 8'd0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h0,   I0,    RUN,   0, 8'd1));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h4,   I1,    RUN,   0, 8'd2));
    vt.push_back(mk(0, 1, 0, 1, 32'hC,   1, 0, 32'h0,   32'h0, RUN,   0, 8'd3));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'hC,   I3,    RUN,   0, 8'd4));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h10,  I4,    RUN,   0, 8'd5));
    // Misaligned redirect: terminal fault, later redirects ignored, pc frozen.
    vt.push_back(mk(0, 1, 0, 1, 32'h6,   1, 0, 32'h0,   32'h0, FAULT, 1, 8'd5));
    vt.push_back(mk(0, 1, 0, 1, 32'h0,   1, 0, 32'h0,   32'h0, FAULT, 1, 8'd5));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,   32'h0, FAULT, 1, 8'd5));
    // Halt drains without pushing; redirect to 0x3FC wraps the ROM index.
    vt.push_back(mk(1, 1, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0, RUN,   0, 8'd0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 32'h0,   I0,    RUN,   0, 8'd1));
    vt.push_back(mk(0, 1, 1, 0, 32'h0,   0, 1, 32'h0,   I0,    HALT,  0, 8'd1));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,   32'h0, HALT,  0, 8'd1));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 32'h0,   32'h0, HALT,  0, 8'd1));
    vt.push_back(mk(0, 1, 0, 1, 32'h3FC, 1, 0, 32'h0,   32'h0, RUN,   0, 8'd255));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h3FC, NP,    RUN,   0, 8'd0));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,   1, 1, 32'h400, I0,    RUN,   0, 8'd1));

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rs) do_reset($sformatf("row%0d reset", i));
      enable       = vt[i].en;
      halt_req     = vt[i].hr;
      redirect_vld = vt[i].rv;
      redirect_pc  = vt[i].rpc;
      out_ready    = vt[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vt[i].ev));
      check($sformatf("row%0d state", i),     32'(state),     32'(vt[i].est));
      check($sformatf("row%0d fault", i),     32'(fault),     32'(vt[i].ef));
      check($sformatf("row%0d rom_addr", i),  32'(rom_addr),  32'(vt[i].erom));
      if (vt[i].ev) begin
        check($sformatf("row%0d out_pc", i),    out_pc,    vt[i].epc);
        check($sformatf("row%0d out_instr", i), out_instr, vt[i].ein);
      end
    end

    // Fault stays set through the reset sequence only until rst_n is asserted.
    do_reset("fault clear");

    // Asynchronous reset mid-stream with a full buffer.
    enable    = 1'b1;
    out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("full before reset out_valid", 32'(out_valid), 32'd1);
    check("full before reset out_pc",    out_pc,         32'h0);
    check("full before reset rom_addr",  32'(rom_addr),  32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    @(posedge clk);
    #1;
    check("held reset state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
